// File: rtl/memtrace_capture.sv
// Memory-trace capture: buffers multi-lane request snapshots stamped with a cycle
// count and serializes them into one record per valid lane on a valid/ready port.

module memtrace_lane_pick #(
  parameter int DATA_WIDTH    = 64,
  parameter int LOGSIZE_WIDTH = 8
) (
  input  logic                     sel,
  input  logic [DATA_WIDTH-1:0]    address,
  input  logic [DATA_WIDTH-1:0]    data,
  input  logic                     is_store,
  input  logic [LOGSIZE_WIDTH-1:0] size,
  output logic [DATA_WIDTH-1:0]    pick_address,
  output logic [DATA_WIDTH-1:0]    pick_data,
  output logic                     pick_is_store,
  output logic [LOGSIZE_WIDTH-1:0] pick_size
);
  assign pick_address  = sel ? address  : '0;
  assign pick_data     = sel ? data     : '0;
  assign pick_is_store = sel & is_store;
  assign pick_size     = sel ? size     : '0;
endmodule

module memtrace_capture #(
  parameter int NUM_LANES     = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int LOGSIZE_WIDTH = 8,
  parameter int DEPTH         = 8,
  parameter int CYCLE_WIDTH   = 64
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_LANES-1:0]               trace_write_valid,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]    trace_write_address,
  input  logic [NUM_LANES-1:0]               trace_write_is_store,
  input  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] trace_write_size,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]    trace_write_data,
  input  logic                               trace_write_finished,
  output logic                               trace_write_ready,
  output logic                               rec_valid,
  input  logic                               rec_ready,
  output logic [CYCLE_WIDTH-1:0]             rec_cycle,
  output logic [7:0]                         rec_lane_id,
  output logic [DATA_WIDTH-1:0]              rec_address,
  output logic [DATA_WIDTH-1:0]              rec_data,
  output logic                               rec_is_store,
  output logic [LOGSIZE_WIDTH-1:0]           rec_size,
  output logic                               rec_last,
  output logic [31:0]                        dropped,
  output logic                               done
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [NUM_LANES-1:0]                    mask;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0]    addr;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0]    data;
    logic [NUM_LANES-1:0]                    is_store;
    logic [NUM_LANES-1:0][LOGSIZE_WIDTH-1:0] size;
    logic [CYCLE_WIDTH-1:0]                  cyc;
  } snap_t;

  typedef enum logic {IDLE, EMIT} state_t;

  snap_t                  mem [DEPTH];
  snap_t                  wr_snap, head, nxt;
  logic [AW:0]            wptr, rptr, rptr_nx, count;
  logic [CYCLE_WIDTH-1:0] cyc;
  logic [NUM_LANES-1:0]   rem_q, rem_d, sel;
  state_t                 state_q, state_d;
  logic                   empty, full, push, drop, pop, more, emit;
  logic                   fin_seen, done_q;

  assign rptr_nx = rptr + (AW+1)'(1);
  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign more    = count > (AW+1)'(1);
  assign head    = mem[rptr[AW-1:0]];
  assign nxt     = mem[rptr_nx[AW-1:0]];

  assign trace_write_ready = !full;
  assign push = trace_write_ready && (|trace_write_valid);
  assign drop = !trace_write_ready && (|trace_write_valid);

  always_comb begin
    wr_snap          = '0;
    wr_snap.mask     = trace_write_valid;
    wr_snap.addr     = trace_write_address;
    wr_snap.data     = trace_write_data;
    wr_snap.is_store = trace_write_is_store;
    wr_snap.size     = trace_write_size;
    wr_snap.cyc      = cyc;
  end

  always_ff @(posedge clock)
    if (push) mem[wptr[AW-1:0]] <= wr_snap;

  // Current record is the lowest still-pending lane of the head snapshot.
  assign emit     = (state_q == EMIT);
  assign sel      = emit ? (rem_q & -rem_q) : '0;
  assign rec_last = emit && ((rem_q & (rem_q - NUM_LANES'(1))) == '0);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        state_d = EMIT;
        rem_d   = head.mask;
      end
      EMIT: if (rec_ready) begin
        rem_d = rem_q & ~sel;
        if (rec_last) begin
          pop = 1'b1;
          if (more) rem_d = nxt.mask;
          else      state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]    pick_addr, pick_data;
  logic [NUM_LANES-1:0][LOGSIZE_WIDTH-1:0] pick_size;
  logic [NUM_LANES-1:0]                    pick_store;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    memtrace_lane_pick #(.DATA_WIDTH(DATA_WIDTH), .LOGSIZE_WIDTH(LOGSIZE_WIDTH)) u_pick (
      .sel(sel[g]), .address(head.addr[g]), .data(head.data[g]),
      .is_store(head.is_store[g]), .size(head.size[g]),
      .pick_address(pick_addr[g]), .pick_data(pick_data[g]),
      .pick_is_store(pick_store[g]), .pick_size(pick_size[g])
    );
  end

  always_comb begin
    rec_address  = '0;
    rec_data     = '0;
    rec_size     = '0;
    rec_lane_id  = '0;
    rec_is_store = |pick_store;
    for (int i = 0; i < NUM_LANES; i++) begin
      rec_address = rec_address | pick_addr[i];
      rec_data    = rec_data | pick_data[i];
      rec_size    = rec_size | pick_size[i];
      if (sel[i]) rec_lane_id = 8'(i);
    end
  end

  assign rec_valid = emit;
  assign rec_cycle = emit ? head.cyc : '0;
  assign done      = done_q || (fin_seen && empty && state_q == IDLE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      cyc      <= '0;
      dropped  <= '0;
      fin_seen <= 1'b0;
      done_q   <= 1'b0;
      state_q  <= IDLE;
      rem_q    <= '0;
    end else begin
      cyc     <= cyc + CYCLE_WIDTH'(1);
      state_q <= state_d;
      rem_q   <= rem_d;
      done_q  <= done;
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr_nx;
      if (drop && dropped != '1) dropped <= dropped + 32'd1;
      if (trace_write_finished) fin_seen <= 1'b1;
    end
  end
endmodule

// File: tb/tb_memtrace_capture.sv
// Bench for memtrace_capture: fixed vector table, directed corner sequences and
// random traffic checked against a snapshot/record queue model.

module tb_memtrace_capture;
  localparam int NL = 4, DW = 64, SW = 8, CW = 64, DEPTH = 8;

  logic              clock = 0, reset = 0;
  logic [NL-1:0]     trace_write_valid = '0, trace_write_is_store = '0;
  logic [DW*NL-1:0]  trace_write_address = '0, trace_write_data = '0;
  logic [SW*NL-1:0]  trace_write_size = '0;
  logic              trace_write_finished = 0, rec_ready = 0;
  logic              trace_write_ready, rec_valid, rec_is_store, rec_last, done;
  logic [CW-1:0]     rec_cycle;
  logic [7:0]        rec_lane_id;
  logic [DW-1:0]     rec_address, rec_data;
  logic [SW-1:0]     rec_size;
  logic [31:0]       dropped;
  logic              d2_ready, d2_valid, d2_store, d2_last, d2_done;
  logic [CW-1:0]     d2_cycle;
  logic [7:0]        d2_lane;
  logic [DW-1:0]     d2_addr, d2_data;
  logic [SW-1:0]     d2_size;
  logic [31:0]       d2_dropped;

  always #5 clock = ~clock;

  memtrace_capture #(.NUM_LANES(NL), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(SW), .DEPTH(DEPTH), .CYCLE_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .trace_write_valid(trace_write_valid),
    .trace_write_address(trace_write_address), .trace_write_is_store(trace_write_is_store),
    .trace_write_size(trace_write_size), .trace_write_data(trace_write_data),
    .trace_write_finished(trace_write_finished), .trace_write_ready(trace_write_ready),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_cycle(rec_cycle), .rec_lane_id(rec_lane_id),
    .rec_address(rec_address), .rec_data(rec_data), .rec_is_store(rec_is_store), .rec_size(rec_size),
    .rec_last(rec_last), .dropped(dropped), .done(done));

  memtrace_capture #(.NUM_LANES(NL), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(SW), .DEPTH(2), .CYCLE_WIDTH(CW)) dut2 (
    .clock(clock), .reset(reset), .trace_write_valid(trace_write_valid),
    .trace_write_address(trace_write_address), .trace_write_is_store(trace_write_is_store),
    .trace_write_size(trace_write_size), .trace_write_data(trace_write_data),
    .trace_write_finished(trace_write_finished), .trace_write_ready(d2_ready),
    .rec_valid(d2_valid), .rec_ready(rec_ready), .rec_cycle(d2_cycle), .rec_lane_id(d2_lane),
    .rec_address(d2_addr), .rec_data(d2_data), .rec_is_store(d2_store), .rec_size(d2_size),
    .rec_last(d2_last), .dropped(d2_dropped), .done(d2_done));

  typedef struct {
    logic [7:0] lane; logic [DW-1:0] addr, data; logic st; logic [SW-1:0] size;
    logic [CW-1:0] cyc; logic last;
  } rec_t;

  rec_t          recq[$];
  int            snap_cnt = 0, checks = 0, errors = 0;
  logic [CW-1:0] cyc_m = 0;
  logic [31:0]   drop_m = 0;
  logic          fin_m = 0, done_m = 0, stall_prev = 0;
  logic [DW-1:0] p_addr, p_data;
  logic [CW-1:0] p_cyc;
  logic [7:0]    p_lane;
  logic          p_last;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic rand_lanes();
    for (int g = 0; g < NL; g++) begin
      trace_write_address[g*DW +: DW] = {$urandom, $urandom};
      trace_write_data[g*DW +: DW]    = {$urandom, $urandom};
      trace_write_size[g*SW +: SW]    = SW'($urandom);
      trace_write_is_store[g]         = 1'($urandom);
    end
  endtask

  // One clock: drive inputs, advance the model by the upcoming edge, check after it.
  task automatic step(input logic rst, input logic [NL-1:0] m, input logic rr, input logic fin);
    rec_t e;
    if (stall_prev) begin
      chk("hold_valid", rec_valid, 1);
      chk("hold_addr", rec_address, p_addr);
      chk("hold_data", rec_data, p_data);
      chk("hold_cycle", rec_cycle, p_cyc);
      chk("hold_lane", rec_lane_id, p_lane);
      chk("hold_last", rec_last, p_last);
    end
    reset = rst; trace_write_valid = m; rec_ready = rr; trace_write_finished = fin;
    if (rst) begin
      logic rdy;
      rdy = snap_cnt < DEPTH;
      chk("ready", trace_write_ready, rdy);
      if (rec_valid && rr) begin
        if (recq.size() == 0) chk("rec_unexpected", rec_valid, 0);
        else begin
          e = recq.pop_front();
          chk("rec_lane", rec_lane_id, e.lane);
          chk("rec_addr", rec_address, e.addr);
          chk("rec_data", rec_data, e.data);
          chk("rec_size", rec_size, e.size);
          chk("rec_store", rec_is_store, e.st);
          chk("rec_cycle", rec_cycle, e.cyc);
          chk("rec_last", rec_last, e.last);
          if (e.last) snap_cnt--;
        end
      end
      if (m != 0) begin
        if (rdy) begin
          for (int g = 0; g < NL; g++) if (m[g]) begin
            e.lane = 8'(g); e.addr = trace_write_address[g*DW +: DW];
            e.data = trace_write_data[g*DW +: DW]; e.size = trace_write_size[g*SW +: SW];
            e.st = trace_write_is_store[g]; e.cyc = cyc_m; e.last = ((m >> (g+1)) == 0);
            recq.push_back(e);
          end
          snap_cnt++;
        end else if (drop_m != 32'hFFFF_FFFF) drop_m++;
      end
      if (fin) fin_m = 1;
      cyc_m++;
    end else begin
      recq.delete(); snap_cnt = 0; cyc_m = 0; drop_m = 0; fin_m = 0; done_m = 0;
    end
    stall_prev = rst && rec_valid && !rr;
    p_addr = rec_address; p_data = rec_data; p_cyc = rec_cycle; p_lane = rec_lane_id; p_last = rec_last;
    @(posedge clock); @(negedge clock);
    chk("dropped", dropped, drop_m);
    done_m = done_m | (fin_m && snap_cnt == 0);
    chk("done", done, done_m);
    if (!rec_valid)
      chk("idle_zero", rec_address | rec_data | rec_cycle | 64'(rec_lane_id) | 64'(rec_size)
                       | 64'({rec_is_store, rec_last}), 0);
  endtask

  typedef struct {
    logic rst; logic [NL-1:0] m;
    logic ev; logic [7:0] lane; logic last; logic [CW-1:0] cyc; logic [DW-1:0] addr;
  } vec_t;

  initial begin
    vec_t tbl[11];
    int got, sent, n;
    logic [NL-1:0] mk;
    @(negedge clock);

    // Table: reset release, then mask 0101 captured at counter 5.
    for (int g = 0; g < NL; g++) trace_write_address[g*DW +: DW] = 64'h1000 + 64'(g * 16);
    tbl[0] = '{0, 4'b0000, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 4'b0000, 0, 0, 0, 0, 0};
    for (int i = 2; i < 7; i++) tbl[i] = '{1, 4'b0000, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 4'b0101, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 4'b0000, 1, 0, 0, 5, 64'h1000};
    tbl[9]  = '{1, 4'b0000, 1, 2, 1, 5, 64'h1020};
    tbl[10] = '{1, 4'b0000, 0, 0, 0, 0, 0};
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst, tbl[i].m, 1, 0);
      chk("tbl_valid", rec_valid, tbl[i].ev);
      chk("tbl_lane", rec_lane_id, tbl[i].lane);
      chk("tbl_last", rec_last, tbl[i].last);
      chk("tbl_cycle", rec_cycle, tbl[i].cyc);
      chk("tbl_addr", rec_address, tbl[i].addr);
      chk("tbl_ready", trace_write_ready, 1);
    end

    // Fill to full with rec_ready low, one drop, then a gapless drain.
    step(0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin rand_lanes(); step(1, 4'hF, 0, 0); end
    chk("full_ready", trace_write_ready, 0);
    rand_lanes(); step(1, 4'hF, 0, 0);
    chk("dropped_one", dropped, 1);
    for (int k = 0; k < 32; k++) begin
      chk("no_gap", rec_valid, 1);
      step(1, 0, 1, 0);
      if (k == 2) chk("ready_before_pop", trace_write_ready, 0);
      if (k == 3) chk("ready_after_pop", trace_write_ready, 1);
    end
    chk("drained_valid", rec_valid, 0);
    chk("drained_queue", recq.size(), 0);

    // Random traffic with random back-pressure.
    step(0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      rand_lanes();
      mk = ($urandom_range(0, 3) == 0) ? 4'h0 : NL'($urandom_range(1, 15));
      step(1, mk, $urandom_range(0, 2) != 0, 0);
    end
    n = 0;
    while (recq.size() > 0 && n < 300) begin step(1, 0, 1, 0); n++; end
    chk("random_drain", recq.size(), 0);

    // Finished with three snapshots queued.
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin rand_lanes(); step(1, NL'($urandom_range(1, 15)), 0, 0); end
    step(1, 0, 0, 1);
    chk("done_pending", done, 0);
    n = 0;
    while (recq.size() > 0 && n < 50) begin step(1, 0, 1, 0); n++; end
    chk("done_set", done, 1);
    rand_lanes(); step(1, 4'h3, 0, 0);
    chk("done_sticky", done, 1);

    // Reset in the middle of a 4-lane snapshot.
    step(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin rand_lanes(); step(1, 4'hF, 0, 0); end
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("rst_valid", rec_valid, 0);
    chk("rst_ready", trace_write_ready, 1);
    chk("rst_dropped", dropped, 0);
    chk("rst_done", done, 0);
    rand_lanes(); step(1, 4'b0001, 1, 0);
    step(1, 0, 0, 0);
    chk("cycle_restart", rec_cycle, 0);
    step(1, 0, 1, 0);

    // DEPTH=2 instance: 20 single-lane snapshots across pointer wraps.
    step(0, 0, 0, 0);
    got = 0; sent = 0; n = 0;
    while (got < 20 && n < 200) begin
      if (d2_valid) begin
        chk("d2_lane", d2_lane, 8'(got % 4));
        chk("d2_addr", d2_addr, 64'(got));
        chk("d2_last", d2_last, 1);
        got++;
      end
      mk = 0;
      if (sent < 20 && d2_ready) begin
        mk = NL'(1) << (sent % 4);
        trace_write_address[(sent % 4)*DW +: DW] = 64'(sent);
        sent++;
      end
      step(1, mk, 1, 0);
      n++;
    end
    chk("d2_count", got, 20);
    chk("d2_dropped", d2_dropped, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
